// File: rtl/gpr_ir_mar_datapath.sv
// Register slice of the FPG8 single-bus CPU: eight GPRs (R7 = PC, R1 = display),
// the instruction register with its field decode, and the memory address register.
module gpr_ir_mar_datapath #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      bus_in,
  output logic [15:0]      bus_out,
  output logic             bus_drive,
  input  logic             GPR_in,
  input  logic             GPR_out,
  input  logic [2:0]       GPR_select,
  input  logic             IR_in,
  input  logic             IR_offset_out,
  input  logic             MAR_in,
  input  logic             r_en,
  input  logic             w_en,
  output logic [15:0]      REG_OUT_IR,
  output logic [3:0]       opcode_out,
  output logic [2:0]       rd_out_1,
  output logic [2:0]       rd_out_2,
  output logic             S,
  output logic [1:0]       shift,
  output logic [2:0]       rs_1,
  output logic [2:0]       rs_2,
  output logic [15:0]      REG_OUT_MAR,
  output logic [15:0]      REG_OUT_1,
  output logic [15:0]      REG_OUT_7
);

  logic [15:0] gpr_q [0:7];
  logic [15:0] gpr_d [0:7];
  logic [15:0] ir_q, ir_d;
  logic [15:0] mar_q, mar_d;
  logic [2:0]  reg_idx_s;
  logic [15:0] offset_s;

  assign REG_OUT_IR  = ir_q;
  assign opcode_out  = ir_q[15:12];
  assign rd_out_1    = ir_q[11:9];
  assign rd_out_2    = ir_q[8:6];
  assign S           = ir_q[8];
  assign shift       = ir_q[7:6];
  assign rs_1        = ir_q[5:3];
  assign rs_2        = ir_q[2:0];
  assign REG_OUT_MAR = mar_q;
  assign REG_OUT_1   = gpr_q[1];
  assign REG_OUT_7   = gpr_q[7];
  assign offset_s    = {{7{ir_q[8]}}, ir_q[8:0]};

  // Translate the control unit's select code into a physical register index
  always_comb begin
    reg_idx_s = 3'd0;
    case (GPR_select)
      3'd0:    reg_idx_s = ir_q[11:9];
      3'd1:    reg_idx_s = ir_q[8:6];
      3'd2:    reg_idx_s = ir_q[5:3];
      3'd3:    reg_idx_s = ir_q[2:0];
      3'd4:    reg_idx_s = 3'd7;
      3'd5:    reg_idx_s = 3'd6;
      3'd6:    reg_idx_s = 3'd0;
      3'd7:    reg_idx_s = 3'd1;
      default: reg_idx_s = 3'd0;
    endcase
  end

  // Bus driver: a GPR read takes priority over the IR offset
  always_comb begin
    bus_out   = 16'h0000;
    bus_drive = 1'b0;
    if (GPR_out) begin
      bus_out   = gpr_q[reg_idx_s];
      bus_drive = 1'b1;
    end else if (IR_offset_out) begin
      bus_out   = offset_s;
      bus_drive = 1'b1;
    end else begin
      bus_out   = 16'h0000;
      bus_drive = 1'b0;
    end
  end

  // Next-state for GPRs, IR and MAR; MAR is frozen during a RAM access
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      gpr_d[i] = gpr_q[i];
    end
    ir_d  = ir_q;
    mar_d = mar_q;
    if (GPR_in) begin
      gpr_d[reg_idx_s] = bus_in;
    end else begin
      gpr_d[reg_idx_s] = gpr_q[reg_idx_s];
    end
    if (IR_in) begin
      ir_d = bus_in;
    end else begin
      ir_d = ir_q;
    end
    if (MAR_in && !(r_en || w_en)) begin
      mar_d = bus_in;
    end else begin
      mar_d = mar_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        gpr_q[i] <= 16'h0000;
      end
      ir_q  <= 16'h0000;
      mar_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      ir_q  <= ir_d;
      mar_q <= mar_d;
    end
  end

endmodule

// File: tb/tb_gpr_ir_mar_datapath.sv
// Directed self-checking bench for gpr_ir_mar_datapath.
module tb_gpr_ir_mar_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_drive;
  logic        GPR_in, GPR_out, IR_in, IR_offset_out, MAR_in, r_en, w_en;
  logic [2:0]  GPR_select;
  logic [15:0] REG_OUT_IR, REG_OUT_MAR, REG_OUT_1, REG_OUT_7;
  logic [3:0]  opcode_out;
  logic [2:0]  rd_out_1, rd_out_2, rs_1, rs_2;
  logic        S;
  logic [1:0]  shift;

  int n_cmp = 0;
  int n_err = 0;

  gpr_ir_mar_datapath dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
    .GPR_in(GPR_in), .GPR_out(GPR_out), .GPR_select(GPR_select), .IR_in(IR_in),
    .IR_offset_out(IR_offset_out), .MAR_in(MAR_in), .r_en(r_en), .w_en(w_en),
    .REG_OUT_IR(REG_OUT_IR), .opcode_out(opcode_out), .rd_out_1(rd_out_1),
    .rd_out_2(rd_out_2), .S(S), .shift(shift), .rs_1(rs_1), .rs_2(rs_2),
    .REG_OUT_MAR(REG_OUT_MAR), .REG_OUT_1(REG_OUT_1), .REG_OUT_7(REG_OUT_7)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    GPR_in = 1'b0; GPR_out = 1'b0; IR_in = 1'b0; IR_offset_out = 1'b0;
    MAR_in = 1'b0; r_en = 1'b0; w_en = 1'b0; GPR_select = 3'd0; bus_in = 16'h0000;
  endtask

  task automatic load_ir(input logic [15:0] v);
    @(negedge clk);
    drive_idle();
    bus_in = v; IR_in = 1'b1;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic write_gpr(input logic [2:0] sel, input logic [15:0] v);
    @(negedge clk);
    drive_idle();
    bus_in = v; GPR_select = sel; GPR_in = 1'b1;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic load_mar(input logic [15:0] v, input logic ren, input logic wen);
    @(negedge clk);
    drive_idle();
    bus_in = v; MAR_in = 1'b1; r_en = ren; w_en = wen;
    @(posedge clk); #1;
    drive_idle();
  endtask

  // Drive GPR_out with a select code and check the bus value
  task automatic read_gpr(input logic [2:0] sel, input logic [15:0] exp, input string name);
    @(negedge clk);
    drive_idle();
    GPR_select = sel; GPR_out = 1'b1;
    #1;
    n_cmp++;
    if (bus_out !== exp || bus_drive !== 1'b1) begin
      n_err++;
      $display("FAIL %s: bus_out=%h drive=%b expected %h drive=1", name, bus_out, bus_drive, exp);
    end
    GPR_out = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (REG_OUT_7 !== 16'h0 || REG_OUT_1 !== 16'h0 || REG_OUT_IR !== 16'h0 ||
        REG_OUT_MAR !== 16'h0 || bus_drive !== 1'b0 || bus_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: R7=%h R1=%h IR=%h MAR=%h drive=%b bus=%h expected all 0",
               REG_OUT_7, REG_OUT_1, REG_OUT_IR, REG_OUT_MAR, bus_drive, bus_out);
    end
  endtask

  task automatic test_gpr_rw();
    load_ir(16'h0000);
    write_gpr(3'd4, 16'hA5A5);
    n_cmp++;
    if (REG_OUT_7 !== 16'hA5A5) begin
      n_err++;
      $display("FAIL r7_write: got %h expected a5a5", REG_OUT_7);
    end
    read_gpr(3'd4, 16'hA5A5, "r7_read");
    write_gpr(3'd7, 16'h1357);
    n_cmp++;
    if (REG_OUT_1 !== 16'h1357) begin
      n_err++;
      $display("FAIL r1_write: got %h expected 1357", REG_OUT_1);
    end
    write_gpr(3'd5, 16'h6666);
    write_gpr(3'd6, 16'h0F0F);
    // IR=0 so rd_out_1 selects R0
    read_gpr(3'd0, 16'h0F0F, "r0_via_rd1");
  endtask

  task automatic test_ir_decode();
    load_ir(16'h3A5D);
    n_cmp++;
    if (REG_OUT_IR !== 16'h3A5D || opcode_out !== 4'd3 || rd_out_1 !== 3'd5 ||
        rd_out_2 !== 3'd1 || S !== 1'b0 || shift !== 2'd1 || rs_1 !== 3'd3 || rs_2 !== 3'd5) begin
      n_err++;
      $display("FAIL ir_fields: ir=%h op=%0d rd1=%0d rd2=%0d S=%b sh=%0d rs1=%0d rs2=%0d expected 3a5d 3 5 1 0 1 3 5",
               REG_OUT_IR, opcode_out, rd_out_1, rd_out_2, S, shift, rs_1, rs_2);
    end
    write_gpr(3'd0, 16'h0042);
    read_gpr(3'd3, 16'h0042, "r5_via_rs2");
    read_gpr(3'd5, 16'h6666, "r6_select");
    read_gpr(3'd1, 16'h1357, "r1_via_rd2");
    read_gpr(3'd2, 16'h0000, "r3_via_rs1");
  endtask

  task automatic test_offset();
    load_ir(16'h01F0);
    @(negedge clk);
    IR_offset_out = 1'b1; #1;
    n_cmp++;
    if (bus_out !== 16'hFFF0 || bus_drive !== 1'b1) begin
      n_err++;
      $display("FAIL offset_neg: bus=%h drive=%b expected fff0 drive=1", bus_out, bus_drive);
    end
    GPR_out = 1'b1; GPR_select = 3'd4; #1;
    n_cmp++;
    if (bus_out !== 16'hA5A5 || bus_drive !== 1'b1) begin
      n_err++;
      $display("FAIL gpr_priority: bus=%h drive=%b expected a5a5 drive=1", bus_out, bus_drive);
    end
    drive_idle(); #1;
    n_cmp++;
    if (bus_out !== 16'h0000 || bus_drive !== 1'b0) begin
      n_err++;
      $display("FAIL bus_idle: bus=%h drive=%b expected 0000 drive=0", bus_out, bus_drive);
    end
    load_ir(16'h00F0);
    @(negedge clk);
    IR_offset_out = 1'b1; #1;
    n_cmp++;
    if (bus_out !== 16'h00F0 || bus_drive !== 1'b1) begin
      n_err++;
      $display("FAIL offset_pos: bus=%h drive=%b expected 00f0 drive=1", bus_out, bus_drive);
    end
    drive_idle();
  endtask

  task automatic test_mar();
    load_mar(16'h0ABC, 1'b0, 1'b0);
    n_cmp++;
    if (REG_OUT_MAR !== 16'h0ABC) begin
      n_err++;
      $display("FAIL mar_load: got %h expected 0abc", REG_OUT_MAR);
    end
    load_mar(16'h0123, 1'b1, 1'b0);
    n_cmp++;
    if (REG_OUT_MAR !== 16'h0ABC) begin
      n_err++;
      $display("FAIL mar_hold_ren: got %h expected 0abc", REG_OUT_MAR);
    end
    load_mar(16'h0456, 1'b0, 1'b1);
    n_cmp++;
    if (REG_OUT_MAR !== 16'h0ABC) begin
      n_err++;
      $display("FAIL mar_hold_wen: got %h expected 0abc", REG_OUT_MAR);
    end
  endtask

  task automatic test_back_to_back();
    write_gpr(3'd7, 16'h0011);
    @(negedge clk);
    GPR_select = 3'd7; GPR_out = 1'b1; GPR_in = 1'b1; bus_in = 16'h0022; #1;
    n_cmp++;
    if (bus_out !== 16'h0011) begin
      n_err++;
      $display("FAIL simul_old: bus=%h expected 0011", bus_out);
    end
    @(posedge clk); #1;
    drive_idle();
    n_cmp++;
    if (REG_OUT_1 !== 16'h0022) begin
      n_err++;
      $display("FAIL simul_new: R1=%h expected 0022", REG_OUT_1);
    end
  endtask

  task automatic test_midrun_reset();
    write_gpr(3'd4, 16'h0123);
    load_ir(16'hFFFF);
    @(negedge clk);
    reset = 1'b1; #1;
    n_cmp++;
    if (REG_OUT_7 !== 16'h0 || REG_OUT_1 !== 16'h0 || REG_OUT_IR !== 16'h0 || REG_OUT_MAR !== 16'h0 ||
        opcode_out !== 4'd0 || rd_out_1 !== 3'd0 || rd_out_2 !== 3'd0 || S !== 1'b0 ||
        shift !== 2'd0 || rs_1 !== 3'd0 || rs_2 !== 3'd0 || bus_drive !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: R7=%h R1=%h IR=%h MAR=%h drive=%b expected all 0",
               REG_OUT_7, REG_OUT_1, REG_OUT_IR, REG_OUT_MAR, bus_drive);
    end
    // Strobe on the same edge as reset must be ignored
    bus_in = 16'hBEEF; IR_in = 1'b1; GPR_in = 1'b1; GPR_select = 3'd4; MAR_in = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (REG_OUT_IR !== 16'h0 || REG_OUT_7 !== 16'h0 || REG_OUT_MAR !== 16'h0) begin
      n_err++;
      $display("FAIL reset_override: IR=%h R7=%h MAR=%h expected 0", REG_OUT_IR, REG_OUT_7, REG_OUT_MAR);
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    reset = 1'b0;
    test_gpr_rw();
    test_ir_decode();
    test_offset();
    test_mar();
    test_back_to_back();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
